// File: rtl/dr_pkg.sv
// rtl/dr_pkg.sv - dual-rail pair codes and FSM state encodings for dr_fork_fifo
package dr_pkg;

    typedef enum logic {
        IN_WAIT = 1'b0,
        IN_ACK  = 1'b1
    } in_state_t;

    typedef enum logic [1:0] {
        O_IDLE = 2'b00,
        O_DATA = 2'b01,
        O_RTZ  = 2'b10
    } out_state_t;

    // Pair layout is {true_rail, false_rail}
    localparam logic [1:0] DR_NULL = 2'b00;
    localparam logic [1:0] DR_T    = 2'b10;
    localparam logic [1:0] DR_F    = 2'b01;
    localparam logic [1:0] DR_ILL  = 2'b11;

endpackage

// File: rtl/dr_word_detect.sv
// rtl/dr_word_detect.sv - combinational complete / spacer / illegal classifier for a dual-rail word
module dr_word_detect
    import dr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] data,
    output logic               complete,
    output logic               spacer,
    output logic               illegal
);

    always_comb begin
        complete = 1'b1;
        spacer   = 1'b1;
        illegal  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (data[2*i +: 2] != DR_T && data[2*i +: 2] != DR_F) complete = 1'b0;
            if (data[2*i +: 2] != DR_NULL) spacer = 1'b0;
            if (data[2*i +: 2] == DR_ILL) illegal = 1'b1;
        end
    end

endmodule

// File: rtl/dr_fork_fifo.sv
// rtl/dr_fork_fifo.sv - 4-phase dual-rail FIFO forking each word to NACK consumers
// Illegal-code (11 pair) checking is enabled by defining DR_FORK_FIFO_ERR_EN.
module dr_fork_fifo
    import dr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int NACK  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2*WIDTH-1:0]       data_in,
    output logic                     ack,
    output logic [2*WIDTH-1:0]       data_out,
    input  logic [NACK-1:0]          ack_in,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    in_state_t              in_state, in_next;
    out_state_t             out_state, out_next;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count_q;
    logic [2*WIDTH-1:0]     mem [DEPTH];
    logic [2*WIDTH-1:0]     data_q, data_next;
    logic                   ack_q, ack_next;
    logic                   in_complete, in_spacer, in_illegal;
    logic                   word_ok, space, push, pop;

    dr_word_detect #(.WIDTH(WIDTH)) u_detect (
        .data     (data_in),
        .complete (in_complete),
        .spacer   (in_spacer),
        .illegal  (in_illegal)
    );

    assign word_ok = in_complete & ~in_illegal;
    assign space   = count_q < CW'(DEPTH);

`ifdef DR_FORK_FIFO_ERR_EN
    logic err_set;
    logic err_q;
`endif

    // Input handshake: next state and push decision
    always_comb begin
        in_next = in_state;
        push    = 1'b0;
`ifdef DR_FORK_FIFO_ERR_EN
        err_set = 1'b0;
`endif
        case (in_state)
            IN_WAIT: begin
                if (word_ok && space) begin
                    in_next = IN_ACK;
                    push    = 1'b1;
                end
`ifdef DR_FORK_FIFO_ERR_EN
                else if (in_illegal) begin
                    in_next = IN_ACK;
                    err_set = 1'b1;
                end
`endif
            end
            IN_ACK: begin
                if (in_spacer) in_next = IN_WAIT;
            end
        endcase
    end

    // Output fork: a partial ack_in pattern holds the state (C-element behaviour)
    always_comb begin
        out_next = out_state;
        pop      = 1'b0;
        case (out_state)
            O_IDLE: if (count_q != '0) out_next = O_DATA;
            O_DATA: if (&ack_in) out_next = O_RTZ;
            O_RTZ: begin
                if (~|ack_in) begin
                    out_next = O_IDLE;
                    pop      = 1'b1;
                end
            end
            default: out_next = O_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave the flops cleanly
    always_comb begin
        ack_next  = (in_next == IN_ACK);
        data_next = (out_next == O_DATA) ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_state  <= IN_WAIT;
            out_state <= O_IDLE;
            ack_q     <= 1'b0;
            data_q    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
        end else begin
            in_state  <= in_next;
            out_state <= out_next;
            ack_q     <= ack_next;
            data_q    <= data_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

`ifdef DR_FORK_FIFO_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign ack      = ack_q;
    assign data_out = data_q;
    assign count    = count_q;

endmodule

// File: tb/tb_dr_fork_fifo.sv
// tb/tb_dr_fork_fifo.sv - directed and randomized checks of dr_fork_fifo against a queue scoreboard
module tb_dr_fork_fifo;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int NACK  = 2;
    localparam int NWORDS = 200;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       ack;
    logic [7:0] data_out;
    logic [1:0] ack_in;
    logic [2:0] count;
    logic       err;
    logic       out_complete, out_spacer, out_illegal;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dr_fork_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NACK(NACK)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .ack      (ack),
        .data_out (data_out),
        .ack_in   (ack_in),
        .count    (count),
        .err      (err)
    );

    dr_word_detect #(.WIDTH(WIDTH)) out_det (
        .data     (data_out),
        .complete (out_complete),
        .spacer   (out_spacer),
        .illegal  (out_illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rand_word();
        logic [7:0] w;
        for (int i = 0; i < WIDTH; i++) w[2*i +: 2] = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
        return w;
    endfunction

    task automatic push_word(input logic [7:0] w, input string tag);
        int n;
        data_in = w;
        n = 0;
        do begin tick(); n++; end while (ack !== 1'b1 && n < 20);
        check({tag, "_ack"}, ack, 1);
        data_in = '0;
        n = 0;
        do begin tick(); n++; end while (ack !== 1'b0 && n < 20);
        check({tag, "_ack_rtz"}, ack, 0);
    endtask

    task automatic consume(input logic [7:0] exp, input string tag);
        int n;
        n = 0;
        while (data_out === 8'h00 && n < 20) begin tick(); n++; end
        check(tag, data_out, exp);
        ack_in = 2'b11;
        tick();
        check({tag, "_rtz"}, data_out, 0);
        ack_in = 2'b00;
        tick();
    endtask

    logic [7:0] w [5];
    logic [7:0] wa, wb, wc, held_w;
    logic [7:0] sb [$];
    int p_state, c_state, sent_n, got_n, held;
    bit pushed;

    initial begin
        rst_n   = 1'b0;
        data_in = 8'h99;
        ack_in  = 2'b00;
        repeat (3) tick();
        check("rst_ack", ack, 0);
        check("rst_data_out", data_out, 0);
        check("rst_count", count, 0);
        check("rst_err", err, 0);

        // Word held across reset release is taken as a new word
        rst_n = 1'b1;
        tick();
        check("rel_ack", ack, 1);
        check("rel_count", count, 1);
        check("rel_data_out_idle", data_out, 0);
        tick();
        check("single_data_out", data_out, 8'h99);
        data_in = 8'h00;
        ack_in  = 2'b01;
        tick();
        check("single_partial_hold", data_out, 8'h99);
        check("single_ack_rtz", ack, 0);
        ack_in = 2'b11;
        tick();
        check("single_out_rtz", data_out, 0);
        ack_in = 2'b00;
        tick();
        check("single_count_pop", count, 0);

        // Full FIFO: consumers hold ack_in low
        for (int i = 0; i < 5; i++) w[i] = rand_word();
        for (int i = 0; i < 4; i++) push_word(w[i], "full_push");
        check("full_count", count, 4);
        check("full_head", data_out, w[0]);
        data_in = w[4];
        repeat (5) tick();
        check("full_no_ack", ack, 0);
        check("full_count_held", count, 4);
        ack_in = 2'b11;
        tick();
        ack_in = 2'b00;
        tick();
        tick();
        check("full_fifth_ack", ack, 1);
        check("full_count_refill", count, 4);
        data_in = 8'h00;
        tick();
        for (int i = 1; i < 5; i++) consume(w[i], "full_drain");
        check("full_drained", count, 0);

        // Incomplete word (pair 0 is spacer)
        data_in = 8'h98;
        repeat (10) tick();
        check("incomplete_ack", ack, 0);
        check("incomplete_count", count, 0);
        data_in = 8'h00;
        tick();

        // Illegal pair 11
        data_in = 8'h9B;
        tick();
`ifdef DR_FORK_FIFO_ERR_EN
        check("illegal_err", err, 1);
        check("illegal_ack", ack, 1);
        check("illegal_count", count, 0);
        data_in = 8'h00;
        tick();
        check("illegal_ack_rtz", ack, 0);
        check("illegal_err_sticky", err, 1);
        rst_n = 1'b0;
        tick();
        check("illegal_err_reset", err, 0);
        rst_n = 1'b1;
        tick();
`else
        repeat (3) tick();
        check("illegal_no_ack", ack, 0);
        check("illegal_no_err", err, 0);
        check("illegal_count", count, 0);
        data_in = 8'h00;
        tick();
`endif

        // Push on the same edge as the RTZ pop
        wa = rand_word();
        wb = rand_word();
        wc = rand_word();
        push_word(wa, "sim_push_a");
        push_word(wb, "sim_push_b");
        check("sim_count_2", count, 2);
        check("sim_head_a", data_out, wa);
        ack_in = 2'b11;
        tick();
        check("sim_out_rtz", data_out, 0);
        data_in = wc;
        ack_in  = 2'b00;
        tick();
        check("sim_count_same", count, 2);
        check("sim_ack", ack, 1);
        data_in = 8'h00;
        tick();
        consume(wb, "sim_order_b");
        consume(wc, "sim_order_c");
        check("sim_drained", count, 0);

        // Randomized producer and two independent consumers against a queue scoreboard
        p_state = 0;
        c_state = 0;
        sent_n  = 0;
        got_n   = 0;
        held    = 0;
        pushed  = 1'b0;
        held_w  = '0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            tick();
            if (p_state == 1 && ack === 1'b1 && !pushed) begin
                sb.push_back(data_in);
                pushed = 1'b1;
            end
            if (p_state == 2 && ack === 1'b0) p_state = 0;

            case (c_state)
                0: begin
                    if (out_complete === 1'b1) begin
                        if (sb.size() == 0) check("rnd_unexpected_word", data_out, 0);
                        else begin
                            held_w = sb.pop_front();
                            check("rnd_order", data_out, held_w);
                            held = 1;
                            got_n++;
                            c_state = 1;
                        end
                    end
                end
                1: begin
                    if (ack_in == 2'b11) begin
                        check("rnd_rtz", data_out, 0);
                        c_state = 2;
                    end else check("rnd_partial_hold", data_out, held_w);
                end
                default: if (ack_in != 2'b00) check("rnd_rtz_hold", data_out, 0);
            endcase
            check("rnd_count", count, sb.size() + held);
            check("rnd_out_code", (out_complete | out_spacer) & ~out_illegal, 1);

            if (p_state == 0 && sent_n < NWORDS && $urandom_range(0, 1) == 1) begin
                data_in = rand_word();
                sent_n++;
                pushed  = 1'b0;
                p_state = 1;
            end else if (p_state == 1 && pushed && $urandom_range(0, 1) == 1) begin
                data_in = 8'h00;
                p_state = 2;
            end

            if (c_state == 1 && $urandom_range(0, 1) == 1) begin
                ack_in[$urandom_range(0, 1)] = 1'b1;
            end else if (c_state == 2 && $urandom_range(0, 1) == 1) begin
                ack_in[$urandom_range(0, 1)] = 1'b0;
                if (ack_in == 2'b00) begin
                    held = 0;
                    c_state = 0;
                end
            end

            if (got_n == NWORDS && p_state == 0 && c_state == 0) break;
        end
        check("rnd_delivered", got_n, NWORDS);
        tick();
        tick();
        check("rnd_final_count", count, 0);
        check("rnd_final_ack", ack, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dr_fork_fifo.md
DR_FORK_FIFO -- requirements
Module: dr_fork_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of dual-rail bits per word.
REQ-002 SHALL have parameter DEPTH, default 4: word capacity, power of two, at least 2.
REQ-003 SHALL have parameter NACK, default 2: number of forked consumers.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port data_in, input, 2*WIDTH: dual-rail word; pair i at [2i+1:2i], true rail is bit 2i+1.
REQ-007 SHALL have port ack, output, 1: 4-phase acknowledge to the producer.
REQ-008 SHALL have port data_out, output, 2*WIDTH: dual-rail word to all consumers.
REQ-009 SHALL have port ack_in, input, NACK: one 4-phase acknowledge per consumer.
REQ-010 SHALL have port count, output, clog2(DEPTH)+1: stored words, including the word at the head.
REQ-011 SHALL have port err, output, 1: sticky illegal-code flag (see REQ-024).
REQ-012 SHALL have all inputs synchronous to clk; no internal synchronisers.

Function
REQ-013 SHALL treat a word as complete when every pair is 01 or 10, and as spacer when every pair is 00.
REQ-014 SHALL run an input FSM with two states:
- IN_WAIT: ack=0. Moves to IN_ACK when the word is complete and count<DEPTH; the word is written on that edge.
- IN_ACK: ack=1. Moves to IN_WAIT when data_in is spacer.
REQ-015 SHALL NOT acknowledge while full; the complete word is held by the producer and accepted on the first edge with count<DEPTH.
REQ-016 SHALL run an output FSM with three states:
- O_IDLE: data_out=0. Moves to O_DATA when count>0.
- O_DATA: data_out = head word. Moves to O_RTZ when all ack_in bits are 1.
- O_RTZ: data_out=0. Moves to O_IDLE when all ack_in bits are 0; the head is popped on that edge.
REQ-017 SHALL implement a generalised C-element rule: a partial ack_in pattern SHALL hold the current output state.
REQ-018 SHALL give a latency of one edge from write to O_DATA when the FIFO was empty and the output FSM was in O_IDLE.
REQ-019 SHALL leave count unchanged on an edge with both a push and a pop; pointers wrap modulo DEPTH.
REQ-020 SHALL register ack and data_out; outputs are glitch-free.

Reset
REQ-021 SHALL, while rst_n=0: ack=0, data_out=0, count=0, err=0, both FSMs in their idle states, pointers 0.
REQ-022 SHALL, on reset mid-transfer, discard stored words; after release, an input that is still complete SHALL be accepted as a new word.

Configuration
REQ-023 SHALL use macro DR_FORK_FIFO_ERR_EN to enable illegal-code checking.
REQ-024 SHALL, with the macro defined:
- A pair equal to 11 in IN_WAIT sets err=1, sticky until reset.
- The word is not stored.
- ack is still raised, and the normal spacer wait follows.
REQ-025 SHALL, without the macro, tie err to 0 and treat 11 pairs as incomplete; the word is never acked.

Structure
REQ-026 SHALL place the FSM state encodings and the DR_NULL (00) / DR_T (10) / DR_F (01) pair constants in package dr_pkg.
REQ-027 SHALL instantiate sub-module dr_word_detect (WIDTH) for the complete, spacer and illegal flags; it is combinational and also used in the output checker of the bench.

Verification (WIDTH=4, DEPTH=4, NACK=2)
REQ-028 SHALL cover reset: rst_n=0 with data_in=8'h99 -> ack=0, data_out=0, count=0; release -> ack=1 next edge.
REQ-029 SHALL cover a single word: data_in=8'h99 -> ack=1 at edge+1, data_out=8'h99 at edge+2. Then ack_in=01 -> data_out held; ack_in=11 -> data_out=0; ack_in=00 -> count=0.
REQ-030 SHALL cover full: ack_in held 00, five words pushed -> four acked, count=4, fifth gets ack=0. Then one full consumer cycle -> fifth acked and count stays 4.
REQ-031 SHALL cover an incomplete word: data_in=8'h98 (pair 0 = 00) held 10 cycles -> ack=0, count=0.
REQ-032 SHALL cover illegal code with the macro: data_in=8'h9B -> err=1, ack=1, count=0; spacer -> ack=0; err stays 1. Without the macro -> ack=0, err=0.
REQ-033 SHALL cover simultaneous push and pop: count=2, push on the same edge as the RTZ pop -> count=2, FIFO order preserved.
